// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: request/response front end for the combinational ALU.
// Requests are registered onto the ALU inputs. Each result is captured with
// its tag into a small response FIFO. Sticky flags and an op counter are kept
// for the control path above.
module alu_issue_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_A,
  input  logic [WIDTH-1:0] req_B,
  input  logic [5:0]       req_funct,
  input  logic [3:0]       req_tag,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [5:0]       alu_funct,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic [3:0]       rsp_flags,
  output logic [3:0]       rsp_tag,
  output logic [3:0]       sticky_flags,
  input  logic             sticky_clr,
  output logic [15:0]      op_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic             iss_valid;
  logic [WIDTH-1:0] iss_A;
  logic [WIDTH-1:0] iss_B;
  logic [5:0]       iss_funct;
  logic [3:0]       iss_tag;

  logic [WIDTH-1:0] mem_out   [DEPTH];
  logic [3:0]       mem_flags [DEPTH];
  logic [3:0]       mem_tag   [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;

  logic fifo_full;
  logic push;
  logic pop;
  logic accept;

  // Full is judged on the current count only; a same-cycle pop does not free a slot.
  assign fifo_full = (count == CW'(DEPTH));
  assign push      = iss_valid && !fifo_full;
  assign pop       = rsp_valid && rsp_ready;
  assign req_ready = !iss_valid || !fifo_full;
  assign accept    = req_valid && req_ready;

  assign alu_A      = iss_A;
  assign alu_B      = iss_B;
  assign alu_funct  = iss_funct;
  assign alu_enable = iss_valid;

  assign rsp_valid = (count != '0);
  assign rsp_out   = mem_out[rptr];
  assign rsp_flags = mem_flags[rptr];
  assign rsp_tag   = mem_tag[rptr];

  // Issue register: load on accept, otherwise drain into the FIFO on push.
  always_ff @(posedge clk) begin
    if (reset) begin
      iss_valid <= 1'b0;
      iss_A     <= '0;
      iss_B     <= '0;
      iss_funct <= '0;
      iss_tag   <= '0;
    end else if (accept) begin
      iss_valid <= 1'b1;
      iss_A     <= req_A;
      iss_B     <= req_B;
      iss_funct <= req_funct;
      iss_tag   <= req_tag;
    end else if (push) begin
      iss_valid <= 1'b0;
    end
  end

  // Response FIFO: storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_out[i]   <= '0;
        mem_flags[i] <= '0;
        mem_tag[i]   <= '0;
      end
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem_out[wptr]   <= alu_out;
        mem_flags[wptr] <= alu_flags;
        mem_tag[wptr]   <= iss_tag;
        wptr            <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Sticky flags and op counter; a push on the clear cycle survives the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_flags <= '0;
      op_count     <= '0;
    end else begin
      sticky_flags <= (sticky_clr ? 4'h0 : sticky_flags) | (push ? alu_flags : 4'h0);
      if (push) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Request/response front end that drives the combinational `ALU` block. It accepts operand/function requests over a valid/ready handshake and registers them onto the ALU input ports. It captures `out`/`flags` with a tag into a response FIFO and returns them over a second valid/ready handshake. It also keeps sticky flags and an operation counter for the control path that sits above the ALU.

## Interface
- `WIDTH`, 32, operand/result width; matches the ALU `WIDTH`.
- `DEPTH`, 4, response FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on the edge where `req_valid && req_ready`.
- `req_A`, `req_B`  in  WIDTH  operands.
- `req_funct`  in  6  ALU function code.
- `req_tag`  in  4  opaque tag returned with the result.
- `alu_A`, `alu_B`  out  WIDTH  to ALU `A`/`B`.
- `alu_funct`  out  6  to ALU `funct`.
- `alu_enable`  out  1  to ALU `enable`.
- `alu_out`  in  WIDTH  from ALU `out` (combinational, same cycle).
- `alu_flags`  in  4  from ALU `flags`.
- `rsp_valid`  out  1  FIFO head valid.
- `rsp_ready`  in  1  consumer pops head on `rsp_valid && rsp_ready`.
- `rsp_out`  out  WIDTH  head result.
- `rsp_flags`  out  4  head flags.
- `rsp_tag`  out  4  head tag.
- `sticky_flags`  out  4  OR of flags of all pushed results since last clear.
- `sticky_clr`  in  1  clear `sticky_flags`.
- `op_count`  out  16  number of results pushed, wraps.

## Operation
- Issue stage: registers `iss_A`, `iss_B`, `iss_funct`, `iss_tag`, and `iss_valid`. `alu_A/B/funct` are driven directly from the issue registers; `alu_enable = iss_valid`.
- `fifo_full = (count == DEPTH)`. `push = iss_valid && !fifo_full`.
- `req_ready = !iss_valid || !fifo_full`, i.e. the issue register is empty or drains this cycle.
- Request accept: load the issue registers and set `iss_valid`. Otherwise, on push, clear `iss_valid`.
- Push writes `{alu_out, alu_flags, iss_tag}` at the FIFO write pointer.
- Pop (`rsp_valid && rsp_ready`) advances the read pointer. `rsp_valid = (count != 0)`. `rsp_*` show the head entry combinationally from storage.
- Pointers are log2(DEPTH) bits and wrap naturally. `count` is log2(DEPTH)+1 bits:
  - +1 on push only, −1 on pop only, unchanged on both.
- Full rule: push is decided on the current `count`. A pop in the same cycle does not make room for a push when full.
- Sticky flags, per edge: `sticky_flags <= (sticky_clr ? 0 : sticky_flags) | (push ? alu_flags : 0)`. A push in the same cycle as `sticky_clr` survives the clear.
- `op_count` increments on every push and wraps from 0xFFFF to 0.
- Results are never dropped and order is preserved: response order equals request order.

## Timing
- Reset, on any edge with `reset=1`:
  - `iss_valid=0`, issue registers 0, so `alu_A/B/funct=0` and `alu_enable=0`.
  - Pointers and `count` = 0, so `rsp_valid=0`; `rsp_*` are don't-care but storage is zeroed (reads 0).
  - `sticky_flags=0`, `op_count=0`.
  - `req_ready=1` from the first cycle after reset.
- Reset mid-operation discards the issue register and all FIFO entries. No response is produced for them.
- Latency: a request accepted at edge k drives the ALU during cycle k→k+1 and is pushed at edge k+1. `rsp_valid` is high after edge k+1, i.e. 2 edges from accept to visible response.
- Throughput: one op per cycle sustained while `rsp_ready=1` (steady-state `count=1`).
- Backpressure with `rsp_ready=0`:
  - DEPTH results fill the FIFO, then one more request is held in the issue register.
  - `req_ready` then drops. It rises the cycle after the first pop.
- Simultaneous push and pop: `count` is unchanged; with a single entry, the head updates to the new entry on the next cycle.

## Test plan
Bench uses a stub ALU: `alu_out = alu_A ^ alu_B`, `alu_flags = alu_funct[3:0]`.
- Reset held for 4 cycles with `req_valid=1` → all outputs 0, `req_ready=1`, no push, `op_count=0`.
- Single request A=0xFA10_070F, B=0x0000_010F, funct=3, tag=5 → 2 edges later `rsp_valid=1`, `rsp_out=0xFA10_0600`, `rsp_flags=3`, `rsp_tag=5`; `op_count=1`, `sticky_flags=3`.
- Back-to-back funct 0..7 with tags 0..7, `rsp_ready=1` → 8 responses in order on 8 consecutive cycles; `sticky_flags=0x7`; `op_count=8`.
- `rsp_ready=0` with requests streaming → exactly DEPTH+1=5 accepted, then `req_ready=0`. Raise `rsp_ready` → `req_ready=1` one cycle after the first pop, and all tags are returned in order.
- `sticky_clr=1` on the same cycle as a push with funct=8 → `sticky_flags=0x8`, not 0. Clear with no push → 0.
- `reset` pulsed with 3 entries queued → `rsp_valid=0` next cycle, `op_count=0`, and no stale response ever appears.
